// File: rtl/ans_decoder.sv
// Streaming ANS decoder: rebuilds symbols from a reversed chunk stream using an external slot lookup.
// Latency: 1 DECODE cycle after state is full, then out_vld; out_rdy low holds EMIT, in_rdy only in LOAD/FILL.
// Optional ANS_DEC_DONE_EN adds the end-of-stream check and drives o_done.
module ans_decoder #(
   parameter int SYM_WIDTH   = 4,
   parameter int STATE_WIDTH = 16,
   parameter int CNT_WIDTH   = 8,
   parameter int INIT_CHUNKS = STATE_WIDTH / SYM_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_ena,
   input  logic [SYM_WIDTH-1:0]          i_in,
   input  logic                          i_in_vld,
   output logic                          o_in_rdy,
   input  logic [STATE_WIDTH-1:0]        i_total_count,
   output logic [STATE_WIDTH-1:0]        o_slot,
   input  logic [SYM_WIDTH-1:0]          i_s_sym,
   input  logic [CNT_WIDTH-1:0]          i_s_count,
   input  logic [SYM_WIDTH+CNT_WIDTH-1:0] i_s_cumulative,
   output logic [SYM_WIDTH-1:0]          o_out,
   output logic                          o_out_vld,
   input  logic                          i_out_rdy,
   output logic                          o_done
);

   localparam int W2 = 2 * STATE_WIDTH;
   localparam int CW = $clog2(INIT_CHUNKS + 1);

   typedef enum logic [2:0] {
      ST_LOAD   = 3'd0,
      ST_DECODE = 3'd1,
      ST_EMIT   = 3'd2,
      ST_FILL   = 3'd3,
      ST_DONE   = 3'd4
   } fsm_t;

   fsm_t                   r_fsm;
   logic [STATE_WIDTH-1:0] r_state;
   logic [CW-1:0]          r_cnt;
   logic [SYM_WIDTH-1:0]   r_out;
   logic                   r_out_vld;
   logic                   r_in_rdy;

   logic [W2-1:0]          w_st2;
   logic [W2-1:0]          w_tot2;
   logic [W2-1:0]          w_quot2;
   logic [STATE_WIDTH-1:0] w_slot;
   logic [STATE_WIDTH-1:0] w_next;
   logic [STATE_WIDTH-1:0] w_shift;
   logic                   w_in_acc;
   logic                   w_out_acc;

   // All decode arithmetic is done at double width and truncated back.
   assign w_st2   = W2'(r_state);
   assign w_tot2  = W2'(i_total_count);
   assign w_quot2 = w_st2 / w_tot2;
   assign w_slot  = STATE_WIDTH'(w_st2 % w_tot2);
   assign w_next  = STATE_WIDTH'(W2'(i_s_count) * w_quot2 + W2'(w_slot) - W2'(i_s_cumulative));
   assign w_shift = STATE_WIDTH'({r_state, i_in});

   assign w_in_acc  = i_in_vld && r_in_rdy && i_ena;
   assign w_out_acc = r_out_vld && i_out_rdy && i_ena;

   assign o_slot    = w_slot;
   assign o_out     = r_out;
   assign o_out_vld = r_out_vld;
   assign o_in_rdy  = r_in_rdy;

`ifdef ANS_DEC_DONE_EN
   localparam logic [STATE_WIDTH-1:0] ONE = {{(STATE_WIDTH-1){1'b0}}, 1'b1};
   logic r_done;
   logic w_term;
   // The encoder starts from total_count+1, so seeing it again marks stream end.
   assign w_term = (r_state == (i_total_count + ONE));
   assign o_done = r_done;
`else
   assign o_done = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm     <= ST_LOAD;
         r_state   <= '0;
         r_cnt     <= '0;
         r_out     <= '0;
         r_out_vld <= 1'b0;
         r_in_rdy  <= 1'b1;
`ifdef ANS_DEC_DONE_EN
         r_done    <= 1'b0;
`endif
      end else if (i_ena) begin
         case (r_fsm)
            ST_LOAD: begin
               if (w_in_acc) begin
                  r_state <= w_shift;
                  r_cnt   <= r_cnt + 1'b1;
                  if (r_cnt == CW'(INIT_CHUNKS - 1)) begin
                     r_fsm    <= ST_DECODE;
                     r_in_rdy <= 1'b0;
                  end
               end
            end
            ST_DECODE: begin
`ifdef ANS_DEC_DONE_EN
               if (w_term) begin
                  r_fsm  <= ST_DONE;
                  r_done <= 1'b1;
               end else
`endif
               begin
                  r_out     <= i_s_sym;
                  r_state   <= w_next;
                  r_fsm     <= ST_EMIT;
                  r_out_vld <= 1'b1;
               end
            end
            ST_EMIT: begin
               if (w_out_acc) begin
                  r_out_vld <= 1'b0;
                  if (r_state < i_total_count) begin
                     r_fsm    <= ST_FILL;
                     r_in_rdy <= 1'b1;
                  end else begin
                     r_fsm <= ST_DECODE;
                  end
               end
            end
            ST_FILL: begin
               if (w_in_acc) begin
                  r_state <= w_shift;
                  if (w_shift >= i_total_count) begin
                     r_fsm    <= ST_DECODE;
                     r_in_rdy <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               r_fsm <= ST_DONE;
            end
            default: begin
               r_fsm <= ST_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ans_decoder.sv
// Bench for ans_decoder: directed scenarios on the A/B table plus randomized streams vs. a reference decoder.
module tb_ans_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        ena = 1'b1;
   logic [3:0]  in_d = '0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [15:0] total_count = 16'd16;
   logic [15:0] slot;
   logic [3:0]  s_sym;
   logic [7:0]  s_count;
   logic [11:0] s_cum;
   logic [3:0]  out_d;
   logic        out_vld;
   logic        out_rdy = 1'b0;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;
   int chunks[$];
   int exp_syms[$];
   bit exp_done;

   always #5 clk = ~clk;

   // Frequency table: A = {0,12,0} covers slots 0..11, B = {1,4,12} covers 12..15.
   always_comb begin
      s_sym   = 4'd0;
      s_count = 8'd12;
      s_cum   = 12'd0;
      if (slot >= 16'd12) begin
         s_sym   = 4'd1;
         s_count = 8'd4;
         s_cum   = 12'd12;
      end
   end

   ans_decoder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_ena          (ena),
      .i_in           (in_d),
      .i_in_vld       (in_vld),
      .o_in_rdy       (in_rdy),
      .i_total_count  (total_count),
      .o_slot         (slot),
      .i_s_sym        (s_sym),
      .i_s_count      (s_count),
      .i_s_cumulative (s_cum),
      .o_out          (out_d),
      .o_out_vld      (out_vld),
      .i_out_rdy      (out_rdy),
      .o_done         (done)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_vld  = 1'b0;
      out_rdy = 1'b0;
      ena     = 1'b1;
      step();
      rst_n = 1'b0;
      #2;
      chk("rst_in_rdy", int'(in_rdy), 1);
      chk("rst_out_vld", int'(out_vld), 0);
      chk("rst_slot", int'(slot), 0);
      chk("rst_out", int'(out_d), 0);
      chk("rst_done", int'(done), 0);
      step();
      rst_n = 1'b1;
   endtask

   task automatic push(input int c);
      bit ok;
      ok     = 1'b0;
      in_d   = 4'(c);
      in_vld = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = in_rdy && ena;
         step();
      end
      in_vld = 1'b0;
      chk("push_acc", int'(ok), 1);
   endtask

   task automatic get_sym(input string tag, input int exp, output int lat);
      bit got;
      got     = 1'b0;
      lat     = 0;
      out_rdy = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         if (out_vld) begin
            chk(tag, int'(out_d), exp);
            got = 1'b1;
         end else begin
            lat++;
         end
         step();
      end
      out_rdy = 1'b0;
      chk({tag, "_seen"}, int'(got), 1);
   endtask

   task automatic load4(input int a, input int b, input int c, input int d);
      push(a); push(b); push(c); push(d);
   endtask

   // Reference decoder over the chunk queue: plain integer arithmetic on the A/B table.
   task automatic build_expected(input int max_syms);
      int st, idx, sl, q;
      bit stop;
      st = 0; idx = 0; stop = 1'b0; exp_done = 1'b0;
      exp_syms.delete();
      for (int i = 0; i < 4; i++) begin
         st = ((st << 4) | chunks[idx]) & 32'hFFFF;
         idx++;
      end
      while (!stop) begin
`ifdef ANS_DEC_DONE_EN
         if (st == 17) begin
            exp_done = 1'b1;
            stop = 1'b1;
            continue;
         end
`endif
         if (exp_syms.size() >= max_syms) begin
            stop = 1'b1;
            continue;
         end
         sl = st % 16;
         q  = st / 16;
         if (sl < 12) begin
            exp_syms.push_back(0);
            st = (12 * q + sl) & 32'hFFFF;
         end else begin
            exp_syms.push_back(1);
            st = (4 * q + sl - 12) & 32'hFFFF;
         end
         while (!stop && st < 16) begin
            if (idx >= chunks.size()) stop = 1'b1;
            else begin
               st = ((st << 4) | chunks[idx]) & 32'hFFFF;
               idx++;
            end
         end
      end
   endtask

   task automatic run_random(input int n_chunks, input int max_syms);
      int idx, k, cyc, both;
      bit acc_in, acc_out;
      do_reset();
      chunks.delete();
      for (int i = 0; i < n_chunks; i++) chunks.push_back(int'($urandom_range(0, 15)));
      build_expected(max_syms);
      idx = 0; k = 0; cyc = 0; both = 0;
      while (k < exp_syms.size() && cyc < 4000) begin
         ena     = ($urandom_range(0, 9) != 0);
         in_vld  = (idx < chunks.size()) && ($urandom_range(0, 3) != 0);
         in_d    = (idx < chunks.size()) ? 4'(chunks[idx]) : 4'd0;
         out_rdy = ($urandom_range(0, 3) != 0);
         acc_in  = in_vld && in_rdy && ena;
         acc_out = out_vld && out_rdy && ena;
         if (in_rdy && out_vld) both++;
         if (acc_out) begin
            chk("rnd_sym", int'(out_d), exp_syms[k]);
            k++;
         end
         step();
         if (acc_in) idx++;
         cyc++;
      end
      in_vld  = 1'b0;
      out_rdy = 1'b0;
      ena     = 1'b1;
      chk("rnd_count", k, exp_syms.size());
      chk("rnd_excl", both, 0);
`ifdef ANS_DEC_DONE_EN
      if (exp_done) begin
         step(); step();
         chk("rnd_done", int'(done), 1);
      end
`endif
   endtask

   task automatic scenario_21();
      int lat, extra;
      load4(0, 0, 1, 5);
      chk("d1_slot", int'(slot), 5);
      get_sym("d1_sym", 0, lat);
      chk("d1_lat", lat, 1);
      chk("d1_slot17", int'(slot), 1);
      step();
`ifdef ANS_DEC_DONE_EN
      chk("d1_done", int'(done), 1);
      chk("d1_rdy", int'(in_rdy), 0);
      extra = 0;
      out_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (out_vld) extra++;
         step();
      end
      out_rdy = 1'b0;
      chk("d1_no_vld", extra, 0);
`else
      extra = 0;
      chk("d1_vld2", int'(out_vld), 1);
      chk("d1_sym2", int'(out_d), 0);
      chk("d1_done0", int'(done), extra);
`endif
   endtask

   initial begin
      int lat;
      do_reset();
      scenario_21();

      do_reset();
      load4(0, 0, 4, 13);
      chk("d2_slot", int'(slot), 13);
      get_sym("d2_sym", 1, lat);
      chk("d2_slot17", int'(slot), 1);
      step();
`ifdef ANS_DEC_DONE_EN
      chk("d2_done", int'(done), 1);
`else
      chk("d2_done0", int'(done), 0);
`endif

      do_reset();
      load4(0, 0, 1, 14);
      chk("d3_slot", int'(slot), 14);
      get_sym("d3_sym", 1, lat);
      chk("d3_slot6", int'(slot), 6);
      chk("d3_fill_rdy", int'(in_rdy), 1);
      push(3);
      chk("d3_slot99", int'(slot), 3);
      get_sym("d3_sym2", 0, lat);
      chk("d3_slot75", int'(slot), 11);
      get_sym("d3_ss_sym", 0, lat);
      chk("d3_ss_lat", lat, 1);

      do_reset();
      load4(0, 0, 1, 14);
      step();
      chk("d4_vld", int'(out_vld), 1);
      in_vld = 1'b1;
      in_d   = 4'd7;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("d4_stall_out", int'(out_d), 1);
         chk("d4_stall_rdy", int'(in_rdy), 0);
      end
      in_vld  = 1'b0;
      ena     = 1'b0;
      out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("d4_ena_vld", int'(out_vld), 1);
      end
      ena = 1'b1;
      get_sym("d4_sym", 1, lat);
      chk("d4_lat", lat, 0);
      chk("d4_slot6", int'(slot), 6);

      do_reset();
      scenario_21();

      for (int r = 0; r < 6; r++) run_random(300, 40);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ans_decoder.md
# ans_decoder

Streaming ANS decoder: the receive-side counterpart of the team's ANS encoder. It consumes the encoder's `SYM_WIDTH`-bit chunk stream in reverse (LIFO) order, which an upstream buffer provides, and reconstructs the original symbol sequence. Symbol lookup is external and combinational: the block presents a slot value, and a frequency table returns the matching symbol, count and cumulative count in the same cycle. Valid/ready handshakes are used on both the chunk input and the symbol output.

## Interface
- `INIT_CHUNKS`, default `` `STATE_WIDTH/`SYM_WIDTH ``: number of chunks loaded MSB-first to form the initial state.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: global enable. When low, all registers hold.
- `in` in `SYM_WIDTH`: stream chunk.
- `in_vld` in 1 / `in_rdy` out 1: chunk handshake.
- `total_count` in `STATE_WIDTH`: table total. Must be nonzero and stable for the whole stream.
- `slot` out `STATE_WIDTH`: combinational `state_reg % total_count`, driven to the lookup table.
- `s_sym` in `SYM_WIDTH`, `s_count` in `CNT_WIDTH`, `s_cumulative` in `SYM_WIDTH+CNT_WIDTH`: lookup result for `slot`.
- `out` out `SYM_WIDTH`: decoded symbol.
- `out_vld` out 1 / `out_rdy` in 1: symbol handshake.
- `done` out 1: stream finished (exists only under the macro; see Configuration).

## Operation
- States are LOAD, DECODE, EMIT, FILL and DONE. Every transition requires `ena`=1.
- Reset values: LOAD, `state_reg`=0, load counter=0, `out`=0, `out_vld`=0, `in_rdy`=1, `done`=0.
- LOAD
  - `in_rdy`=1.
  - Each accepted chunk: `state_reg <= (state_reg << SYM_WIDTH) | in`, and the counter increments.
  - After the `INIT_CHUNKS`-th chunk: go to DECODE.
- DECODE (one cycle, `in_rdy`=0, `out_vld`=0)
  - Under the macro, if `state_reg == total_count+1`: go to DONE without emitting.
  - Otherwise: `out <= s_sym`, `state_reg <= s_count*(state_reg/total_count) + slot - s_cumulative`, go to EMIT.
- EMIT
  - `out_vld`=1 and `out` held stable.
  - On `out_vld && out_rdy`: go to FILL if `state_reg < total_count`, else go to DECODE.
- FILL
  - `in_rdy`=1.
  - Each accepted chunk shifts into `state_reg` as in LOAD.
  - When the new value is `>= total_count`: go to DECODE. Otherwise stay in FILL.
- DONE: `done`=1, `in_rdy`=0, `out_vld`=0. Held until reset.
- Arithmetic
  - Quotient, remainder and product are computed at `2*STATE_WIDTH` and truncated to `STATE_WIDTH`.
  - Shift-in drops high bits.
  - Overflow or inconsistent lookup data is a stream error. It is not detected; behaviour is undefined but must not lock the handshake.

## Timing
- `in_rdy` and `out_vld` are registered outputs. They are never both 1 in the same cycle.
- Input acceptance:
  - Accepted only when `in_vld && in_rdy && ena`.
  - `in_vld` while `in_rdy`=0 is ignored; the chunk is not consumed.
- Decode latency:
  - LOAD to first `out_vld`: the last LOAD accept, then 1 DECODE cycle, then `out_vld`=1 on the next cycle.
  - Steady state with `out_rdy`=1 and no renormalisation: one symbol every 2 cycles.
- `out_rdy` low holds EMIT indefinitely, with `out` stable.
- `ena`=0 in any state freezes the state and the outputs. Handshakes are not accepted while `ena`=0.
- Asynchronous reset mid-stream returns immediately to the reset values; the partial stream is discarded.
- `slot` follows `state_reg` combinationally and is valid every cycle. The lookup inputs are sampled only in DECODE.

## Configuration
- `ANS_DEC_DONE_EN` defined:
  - The termination check in DECODE is present.
  - The `done` port exists and goes to 1 when `state_reg` returns to the encoder's initial value `total_count+1`.
- `ANS_DEC_DONE_EN` undefined:
  - There is no DONE state and the block is free-running.
  - `done` is tied to 0.
  - The consumer counts symbols itself.

## Test plan
All scenarios use `SYM_WIDTH`=4, `STATE_WIDTH`=16, `INIT_CHUNKS`=4, `total_count`=16. The table is A={sym 0, count 12, cum 0} and B={sym 1, count 4, cum 12}.
- Load chunks 0,0,1,5 (state 21) -> `slot`=5, `out`=0 (A), then with the macro `done`=1. No second `out_vld`.
- Load state 77 -> `slot`=13, `out`=1 (B), new state 17, `done`=1.
- Load state 30 -> `out`=1, state 6, enter FILL. Chunk 3 -> state 99, `out`=0, state 75.
- Hold `out_rdy`=0 for 5 cycles in EMIT, and pulse `in_vld` during them -> `out` stable, no chunk consumed.
- Pulse `rst_n` low during FILL -> `in_rdy`=1, `out_vld`=0, state 0, LOAD restarts cleanly.
- Without the macro: load 21 -> `out`=0, then the block continues to DECODE with `done`=0.
